// File: rtl/wash_bay_scheduler.sv
// ---------------------------------------------------------------------------
// wash_bay_scheduler
//   Shares one washing-machine core between N_REQ paid customer slots.
//   A pending slot is picked round-robin (search starts just after the last
//   granted slot). The scheduler then holds coin_in/double_wash to the core
//   for a whole programme and waits for wash_done. After that it pulses
//   `served` to that slot for one cycle (DRAIN). A watchdog stops a programme
//   that never finishes and parks the block in FAULT until clr_fault_i.
//
// Ports
//   clk_i        system clock, everything on posedge
//   rst_n_i      synchronous active-low reset
//   req_i        per-slot level: coin paid, wash wanted (held until served)
//   dbl_req_i    per-slot double-wash option, sampled at grant only
//   clr_fault_i  one-cycle pulse: leave FAULT
//   wm_done_i    wash_done from the machine core (pulse or level)
//   wm_coin_o    coin_in to the core, high for the whole granted programme
//   wm_double_o  double_wash to the core, latched at grant
//   gnt_o        one-hot slot being served, zero otherwise
//   served_o     one-cycle pulse on the slot whose programme completed
//   busy_o       high in RUN and DRAIN
//   fault_o      high while in FAULT
// ---------------------------------------------------------------------------
module wash_bay_scheduler #(
    parameter int              N_REQ   = 4,
    parameter int              TO_W    = 32,
    parameter logic [TO_W-1:0] TIMEOUT = 32'd3_000_000_000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] dbl_req_i,
    input  logic             clr_fault_i,
    input  logic             wm_done_i,
    output logic             wm_coin_o,
    output logic             wm_double_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] served_o,
    output logic             busy_o,
    output logic             fault_o
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FAULT} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic              coin_q, coin_d;
    logic              dbl_q, dbl_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  served_q, served_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;

    // Round-robin pick: walk ptr+N .. ptr+1 so the closest set slot after
    // ptr is the last one written and wins.
    logic              found;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     idx;

    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = ptr_q;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = PW'((int'(ptr_q) + i) % N_REQ);
            if (req_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wdog_d   = wdog_q;
        coin_d   = coin_q;
        dbl_d    = dbl_q;
        gnt_d    = gnt_q;
        served_d = '0;
        busy_d   = busy_q;
        fault_d  = fault_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    ptr_d   = sel;
                    gnt_d   = N_REQ'(1) << sel;
                    coin_d  = 1'b1;
                    dbl_d   = dbl_req_i[sel];
                    wdog_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // Completion beats the watchdog when both land together.
                if (wm_done_i) begin
                    state_d  = DRAIN;
                    coin_d   = 1'b0;
                    dbl_d    = 1'b0;
                    gnt_d    = '0;
                    served_d = gnt_q;
                end else if (wdog_q == TIMEOUT - TO_W'(1)) begin
                    state_d = FAULT;
                    coin_d  = 1'b0;
                    dbl_d   = 1'b0;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    fault_d = 1'b1;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + TO_W'(1);
                end
            end
            DRAIN: begin
                // Single cycle; IDLE follows, so coin_in stays low >= 2 cycles.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            FAULT: begin
                // ptr kept: the faulted slot is searched last on retry.
                if (clr_fault_i) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(N_REQ - 1);
            wdog_q   <= '0;
            coin_q   <= 1'b0;
            dbl_q    <= 1'b0;
            gnt_q    <= '0;
            served_q <= '0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wdog_q   <= wdog_d;
            coin_q   <= coin_d;
            dbl_q    <= dbl_d;
            gnt_q    <= gnt_d;
            served_q <= served_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign wm_coin_o   = coin_q;
    assign wm_double_o = dbl_q;
    assign gnt_o       = gnt_q;
    assign served_o    = served_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault_q;
endmodule

// File: tb/tb_wash_bay_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wash_bay_scheduler
//   Directed bench. A queue-of-customers model (who is on the machine, how
//   long it has run, who just finished, whether the watchdog tripped) is
//   advanced every posedge and compared with all DUT outputs at every negedge.
//   Hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_wash_bay_scheduler;
    localparam int N  = 4;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0, dbl = '0;
    logic         clr = 1'b0, done = 1'b0;
    logic         coin, wdbl, busy, fault;
    logic [N-1:0] gnt, served;

    int vectors = 0;
    int miscompares = 0;
    bit en = 1'b0;

    wash_bay_scheduler #(.N_REQ(N), .TO_W(32), .TIMEOUT(32'(TO))) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .dbl_req_i(dbl),
        .clr_fault_i(clr), .wm_done_i(done), .wm_coin_o(coin),
        .wm_double_o(wdbl), .gnt_o(gnt), .served_o(served),
        .busy_o(busy), .fault_o(fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int serving;    // slot on the machine, -1 if none
        int ran;        // RUN cycles completed by the current programme
        int finished;   // slot whose programme ended last cycle, -1 if none
        bit tripped;    // watchdog fired, waiting for clear
        int last;       // most recently granted slot
        bit dbl;        // double-wash option of the current programme
    } mdl_t;

    mdl_t m = '{serving: -1, ran: 0, finished: -1, tripped: 1'b0, last: N-1, dbl: 1'b0};

    function automatic mdl_t step(mdl_t s, logic r, logic [N-1:0] rq,
                                  logic [N-1:0] db, logic c, logic d);
        mdl_t n = s;
        if (!r) begin
            n = '{serving: -1, ran: 0, finished: -1, tripped: 1'b0, last: N-1, dbl: 1'b0};
        end else if (s.serving >= 0) begin
            if (d) begin
                n.finished = s.serving;
                n.serving  = -1;
            end else if (s.ran + 1 == TO) begin
                n.serving = -1;
                n.tripped = 1'b1;
            end else begin
                n.ran = s.ran + 1;
            end
        end else if (s.finished >= 0) begin
            n.finished = -1;
        end else if (s.tripped) begin
            if (c) n.tripped = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int slot;
                slot = (s.last + k) % N;
                if (rq[slot] && n.serving < 0) begin
                    n.serving = slot;
                    n.last    = slot;
                    n.dbl     = db[slot];
                    n.ran     = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] onehot(int s);
        logic [N-1:0] v;
        v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) m <= step(m, rst_n, req, dbl, clr, done);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("m_coin",   32'(coin),   32'(m.serving >= 0));
            chk("m_double", 32'(wdbl),   32'(m.serving >= 0 && m.dbl));
            chk("m_gnt",    32'(gnt),    32'(onehot(m.serving)));
            chk("m_served", 32'(served), 32'(onehot(m.finished)));
            chk("m_busy",   32'(busy),   32'(m.serving >= 0 || m.finished >= 0));
            chk("m_fault",  32'(fault),  32'(m.tripped));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    int exp2 [5] = '{0, 1, 2, 3, 0};
    int exp4 [4] = '{3, 0, 1, 2};

    initial begin
        tick(1);
        en = 1'b1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_coin", 32'(coin), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fault", 32'(fault), 0);
        rst_n = 1'b1;

        // 1: single request, single programme
        req = 4'b0001;
        tick(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_coin", 32'(coin), 1);
        chk("t1_dbl", 32'(wdbl), 0);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        tick(3);
        done = 1'b1; tick(1); done = 1'b0;
        chk("t1_served", 32'(served), 32'h1);
        chk("t1_coin_off", 32'(coin), 0);
        tick(1);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_served", 32'(served), 0);

        // 2: all slots requesting after reset, order 0,1,2,3,0
        rst_n = 1'b0; tick(1); rst_n = 1'b1; req = 4'b1111;
        tick(1);
        for (int g = 0; g < 5; g++) begin
            chk("t2_gnt", 32'(gnt), 32'(onehot(exp2[g])));
            chk("t2_coin_on", 32'(coin), 1);
            tick(9);
            done = 1'b1; tick(1); done = 1'b0;
            chk("t2_drain_coin", 32'(coin), 0);
            chk("t2_served", 32'(served), 32'(onehot(exp2[g])));
            tick(1);
            chk("t2_idle_coin", 32'(coin), 0);
            if (g == 4) req = '0;
            tick(1);
        end
        chk("t2_end_idle", 32'(gnt), 0);

        // 3: slot 1 just served, req 0011 -> slot 0 next
        req = 4'b0010; tick(1); req = '0;
        chk("t3_pre_gnt", 32'(gnt), 32'h2);
        done = 1'b1; tick(1); done = 1'b0; tick(1);
        req = 4'b0011; tick(1);
        chk("t3_gnt", 32'(gnt), 32'h1);
        req = '0; done = 1'b1; tick(1); done = 1'b0; tick(1);

        // 4: watchdog fault on slot 2, retry order 3,0,1,2
        req = 4'b0100; tick(1);
        chk("t4_gnt", 32'(gnt), 32'h4);
        req = 4'b1111;
        tick(TO - 1);
        chk("t4_last_run_coin", 32'(coin), 1);
        chk("t4_last_run_fault", 32'(fault), 0);
        tick(1);
        chk("t4_fault", 32'(fault), 1);
        chk("t4_fault_coin", 32'(coin), 0);
        chk("t4_fault_served", 32'(served), 0);
        tick(3);
        chk("t4_fault_held", 32'(fault), 1);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("t4_cleared", 32'(fault), 0);
        tick(1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_retry_gnt", 32'(gnt), 32'(onehot(exp4[k])));
            done = 1'b1; tick(1); done = 1'b0; tick(1);
            if (k == 3) req = '0;
            tick(1);
        end

        // 5: wm_done on the last allowed RUN cycle -> served, no fault
        req = 4'b0001; tick(1); req = '0;
        chk("t5_gnt", 32'(gnt), 32'h1);
        tick(TO - 1);
        done = 1'b1; tick(1); done = 1'b0;
        chk("t5_served", 32'(served), 32'h1);
        chk("t5_no_fault", 32'(fault), 0);
        tick(1);

        // 6: reset mid-RUN with double wash
        req = 4'b0010; dbl = 4'b0010; tick(1);
        chk("t6_dbl", 32'(wdbl), 1);
        chk("t6_gnt", 32'(gnt), 32'h2);
        tick(3);
        rst_n = 1'b0; tick(1);
        chk("t6_rst_dbl", 32'(wdbl), 0);
        chk("t6_rst_coin", 32'(coin), 0);
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_served", 32'(served), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        rst_n = 1'b1; req = 4'b1111; dbl = '0; tick(1);
        chk("t6_after_gnt", 32'(gnt), 32'h1);
        req = '0; done = 1'b1; tick(1); done = 1'b0; tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
